// File: rtl/pc_seq_unit.sv
// Fetch-stage PC: priority next-PC select, stall, halt/resume FSM.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_seq_unit #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = 32'h00000000,
  parameter logic [ADDR_W-1:0] EXC_VEC   = 32'h00000380,
  parameter int unsigned       INC       = 4,
  parameter int unsigned       RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_we,
  input  logic              halt_i,
  input  logic              resume_i,
  input  logic              exc_en,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_addr,
  input  logic              jmp_en,
  input  logic [ADDR_W-1:0] jmp_addr,
  input  logic              call_i,
  input  logic              ret_i,
  output logic [ADDR_W-1:0] pc,
  output logic              ce,
  output logic [ADDR_W-1:0] next_pc,
  output logic              halted,
  output logic              ras_empty,
  output logic              ras_err
);

  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              ce_q, ce_d;
  logic [ADDR_W-1:0] seq_pc, pc_nxt;

  function automatic logic [ADDR_W-1:0] align(
    input logic [ADDR_W-1:0] a
  );
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

  assign seq_pc = pc_q + ADDR_W'(INC);

`ifdef PC_RAS_EN
  localparam int unsigned PW = $clog2(RAS_DEPTH);

  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0]     ptr_q;
  logic [PW:0]       cnt_q;
  logic              err_q;
  logic [PW-1:0]     top_idx;
  logic              adv, ras_hit, do_pop, do_push;
  logic              full, ovf, unf;

  // ptr_q is the next free slot; the top sits one below it
  assign top_idx = ptr_q - 1'b1;
  assign ras_hit = ret_i && (cnt_q != '0);
  assign adv     = (state_q == RUN) && pc_we
                && !exc_en && !halt_i;
  assign do_pop  = adv && ras_hit;
  assign do_push = adv && call_i;
  assign full    = (cnt_q == (PW+1)'(RAS_DEPTH));
  assign ovf     = do_push && !do_pop && full;
  assign unf     = adv && ret_i && !ras_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < int'(RAS_DEPTH); i++)
        ras_q[i] <= '0;
    end else begin
      err_q <= ovf | unf;
      if (do_push && do_pop) begin
        ras_q[top_idx] <= seq_pc;
      end else if (do_push) begin
        ras_q[ptr_q] <= seq_pc;
        ptr_q        <= ptr_q + 1'b1;
        if (!full)
          cnt_q <= cnt_q + 1'b1;
      end else if (do_pop) begin
        ptr_q <= top_idx;
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign ras_empty = (cnt_q == '0);
  assign ras_err   = err_q;
`else
  logic unused_ras;
  assign unused_ras = call_i | ret_i;
  assign ras_empty  = 1'b1;
  assign ras_err    = 1'b0;
`endif

  always_comb begin
    pc_nxt = seq_pc;
    if (exc_en)
      pc_nxt = align(EXC_VEC);
`ifdef PC_RAS_EN
    else if (ras_hit)
      pc_nxt = align(ras_q[top_idx]);
`endif
    else if (br_taken)
      pc_nxt = align(br_addr);
    else if (jmp_en)
      pc_nxt = align(jmp_addr);
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ce_d    = ce_q;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
        ce_d    = 1'b1;
      end
      RUN: begin
        if (exc_en) begin
          pc_d = pc_nxt;
        end else if (pc_we) begin
          if (halt_i) begin
            state_d = HALTED;
            ce_d    = 1'b0;
          end else begin
            pc_d = pc_nxt;
          end
        end
      end
      HALTED: begin
        if (exc_en) begin
          state_d = RUN;
          ce_d    = 1'b1;
          pc_d    = pc_nxt;
        end else if (resume_i) begin
          state_d = RUN;
          ce_d    = 1'b1;
        end
      end
      default: begin
        state_d = BOOT;
        ce_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      ce_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ce_q    <= ce_d;
    end
  end

  assign pc      = pc_q;
  assign ce      = ce_q;
  assign next_pc = pc_nxt;
  assign halted  = (state_q == HALTED);

endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed bench for pc_seq_unit with a queue-based reference model
// and a per-cycle compare process.
module tb_pc_seq_unit;

`ifdef PC_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_we, halt_i, resume_i, exc_en;
  logic        br_taken, jmp_en, call_i, ret_i;
  logic [31:0] br_addr, jmp_addr;
  logic [31:0] pc, next_pc;
  logic        ce, halted, ras_empty, ras_err;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  logic [31:0] m_pc;
  bit          m_boot, m_halt, m_err;
  logic [31:0] m_ras[$];

  pc_seq_unit dut (
    .clk(clk), .rst(rst), .pc_we(pc_we),
    .halt_i(halt_i), .resume_i(resume_i),
    .exc_en(exc_en),
    .br_taken(br_taken), .br_addr(br_addr),
    .jmp_en(jmp_en), .jmp_addr(jmp_addr),
    .call_i(call_i), .ret_i(ret_i),
    .pc(pc), .ce(ce), .next_pc(next_pc),
    .halted(halted), .ras_empty(ras_empty),
    .ras_err(ras_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_next();
    if (exc_en) return 32'h380;
    if (RAS && ret_i && m_ras.size() > 0)
      return m_ras[m_ras.size()-1] & ~32'h3;
    if (br_taken) return br_addr & ~32'h3;
    if (jmp_en) return jmp_addr & ~32'h3;
    return m_pc + 32'd4;
  endfunction

  task automatic model_reset();
    m_pc   = 32'h0;
    m_boot = 1'b1;
    m_halt = 1'b0;
    m_err  = 1'b0;
    m_ras.delete();
  endtask

  task automatic model_edge();
    logic [31:0] nx;
    bit hit;
    nx  = model_next();
    hit = RAS && ret_i && (m_ras.size() > 0);
    m_err = 1'b0;
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (exc_en) begin
      m_pc   = 32'h380;
      m_halt = 1'b0;
    end else if (m_halt) begin
      if (resume_i) m_halt = 1'b0;
    end else if (pc_we) begin
      if (halt_i) begin
        m_halt = 1'b1;
      end else begin
        if (RAS) begin
          if (ret_i && !hit) m_err = 1'b1;
          if (hit) void'(m_ras.pop_back());
          if (call_i) begin
            if (m_ras.size() == DEPTH) begin
              m_ras.delete(0);
              m_err = 1'b1;
            end
            m_ras.push_back(m_pc + 32'd4);
          end
        end
        m_pc = nx;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  always @(negedge clk) begin
    if (rst && chk_en) begin
      chk("pc", pc, m_pc);
      chk("ce", 32'(ce), 32'(!m_boot && !m_halt));
      chk("halted", 32'(halted), 32'(m_halt));
      chk("next_pc", next_pc, model_next());
      chk("ras_err", 32'(ras_err), 32'(m_err));
      chk("ras_empty", 32'(ras_empty),
          32'(m_ras.size() == 0));
    end
  end

  initial begin
    logic [31:0] prev;
    logic [31:0] rets [4];
    rets = '{32'h1304, 32'h1204, 32'h1104, 32'h1004};
    {pc_we, halt_i, resume_i, exc_en} = '0;
    {br_taken, jmp_en, call_i, ret_i} = '0;
    br_addr  = '0;
    jmp_addr = '0;
    rst = 1'b0;
    model_reset();
    #3;
    chk("rst_pc", pc, 32'h0);
    chk("rst_ce", 32'(ce), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_empty", 32'(ras_empty), 32'h1);
    chk("rst_err", 32'(ras_err), 32'h0);
    #4 rst = 1'b1;
    chk_en = 1'b1;
    pc_we  = 1'b1;
    exc_en = 1'b1;
    tick();
    chk("boot_pc", pc, 32'h0);
    chk("boot_ce", 32'(ce), 32'h1);
    exc_en = 1'b0;
    tick();
    chk("seq_4", pc, 32'h4);
    tick();
    chk("seq_8", pc, 32'h8);
    tick();
    tick();
    chk("seq_10", pc, 32'h10);
    br_taken = 1'b1; br_addr  = 32'h40;
    jmp_en   = 1'b1; jmp_addr = 32'h80;
    #1 chk("npc_br", next_pc, 32'h40);
    tick();
    chk("br_pri", pc, 32'h40);
    {br_taken, jmp_en} = '0;
    pc_we = 1'b0;
    tick();
    tick();
    chk("stall_pc", pc, 32'h40);
    chk("stall_ce", 32'(ce), 32'h1);
    pc_we = 1'b1;
    jmp_en = 1'b1; jmp_addr = 32'h20;
    tick();
    jmp_en = 1'b0;
    halt_i = 1'b1;
    tick();
    chk("halt_h", 32'(halted), 32'h1);
    chk("halt_ce", 32'(ce), 32'h0);
    chk("halt_pc", pc, 32'h20);
    halt_i = 1'b0;
    br_taken = 1'b1; br_addr = 32'h98;
    tick();
    chk("halt_br", pc, 32'h20);
    br_taken = 1'b0;
    halt_i = 1'b1; resume_i = 1'b1;
    tick();
    chk("res_h", 32'(halted), 32'h0);
    chk("res_ce", 32'(ce), 32'h1);
    chk("res_pc", pc, 32'h20);
    {halt_i, resume_i} = '0;
    tick();
    chk("res_seq", pc, 32'h24);
    halt_i = 1'b1;
    tick();
    halt_i = 1'b0;
    exc_en = 1'b1;
    tick();
    chk("hexc_pc", pc, 32'h380);
    chk("hexc_h", 32'(halted), 32'h0);
    chk("hexc_ce", 32'(ce), 32'h1);
    exc_en = 1'b0;
    jmp_en = 1'b1; jmp_addr = 32'h203;
    tick();
    chk("align", pc, 32'h200);
    jmp_en = 1'b0;
    pc_we = 1'b0; exc_en = 1'b1;
    tick();
    chk("exc_stall", pc, 32'h380);
    exc_en = 1'b0; pc_we = 1'b1;
    jmp_en = 1'b1; jmp_addr = 32'hFFFF_FFFC;
    tick();
    jmp_en = 1'b0;
    tick();
    chk("wrap", pc, 32'h0);
`ifdef PC_RAS_EN
    jmp_en = 1'b1; jmp_addr = 32'h100;
    tick();
    call_i = 1'b1; jmp_addr = 32'h200;
    tick();
    chk("call_pc", pc, 32'h200);
    chk("call_ne", 32'(ras_empty), 32'h0);
    {call_i, jmp_en} = '0;
    tick();
    ret_i = 1'b1;
    br_taken = 1'b1; br_addr = 32'h500;
    tick();
    chk("ret_pc", pc, 32'h104);
    {ret_i, br_taken} = '0;
    for (int k = 0; k < 5; k++) begin
      call_i = 1'b1; jmp_en = 1'b1;
      jmp_addr = 32'h1000 + 32'(k) * 32'h100;
      tick();
    end
    chk("ovf_err", 32'(ras_err), 32'h1);
    {call_i, jmp_en} = '0;
    tick();
    for (int k = 0; k < 4; k++) begin
      ret_i = 1'b1;
      tick();
      chk("ret_n", pc, rets[k]);
    end
    prev = m_pc;
    tick();
    chk("unf_err", 32'(ras_err), 32'h1);
    chk("unf_pc", pc, prev + 32'd4);
    ret_i = 1'b0;
`else
    prev = m_pc;
    call_i = 1'b1; ret_i = 1'b1;
    tick();
    chk("noras_pc", pc, prev + 32'd4);
    chk("noras_err", 32'(ras_err), 32'h0);
    {call_i, ret_i} = '0;
`endif
    call_i = 1'b1;
    tick();
    call_i = 1'b0;
    br_taken = 1'b1; br_addr = 32'h700;
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_ce", 32'(ce), 32'h0);
    chk("arst_empty", 32'(ras_empty), 32'h1);
    chk("arst_h", 32'(halted), 32'h0);
    br_taken = 1'b0;
    #10 rst = 1'b1;
    tick();
    tick();
    chk("post_rst", pc, 32'h4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
